// File: rtl/top.sv
// Single-cycle 32-bit MIPS subset system: core, fixed self-check program ROM and data RAM.
// Store traffic is exported so the surrounding environment can judge pass/fail.
module top #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned IA_W  = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned DA_W  = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] pc_jump;
    logic [29:0]     pc_word;
    logic [IA_W-1:0] imem_idx;
    logic [XLEN-1:0] instr;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm_ext;

    logic            regwrite;
    logic            regdst;
    logic            alusrc;
    logic            memtoreg;
    logic            mem_we;
    logic            branch;
    logic            jump;
    alu_op_e         alu_op;

    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RA_W-1:0] wa;
    logic [XLEN-1:0] result;

    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] aluresult;
    logic            zero;

    logic [XLEN-1:0] dmem [DMEM_WORDS];
    logic [DA_W-1:0] dmem_idx;
    logic [XLEN-1:0] readdata;

    // Fixed self-check program; every word past the listing is sll $0 (nop).
    function automatic logic [XLEN-1:0] rom_word(input logic [IA_W-1:0] idx);
        case (32'(idx))
            32'd0:   rom_word = 32'h20020005;
            32'd1:   rom_word = 32'h2003000c;
            32'd2:   rom_word = 32'h2067fff7;
            32'd3:   rom_word = 32'h00e22025;
            32'd4:   rom_word = 32'h00642824;
            32'd5:   rom_word = 32'h00a42820;
            32'd6:   rom_word = 32'h10a7000a;
            32'd7:   rom_word = 32'h0064202a;
            32'd8:   rom_word = 32'h10800001;
            32'd9:   rom_word = 32'h20050000;
            32'd10:  rom_word = 32'h00e2202a;
            32'd11:  rom_word = 32'h00853820;
            32'd12:  rom_word = 32'h00e23822;
            32'd13:  rom_word = 32'hac670044;
            32'd14:  rom_word = 32'h8c020050;
            32'd15:  rom_word = 32'h08000011;
            32'd16:  rom_word = 32'h20020001;
            32'd17:  rom_word = 32'hac020054;
            default: rom_word = '0;
        endcase
    endfunction

    // Fetch
    assign pc_word  = pc[31:2];
    assign imem_idx = IA_W'(pc_word % 30'(IMEM_WORDS));
    assign instr    = rom_word(imem_idx);

    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    // Main decoder; unrecognised opcode/funct falls through as a nop
    always_comb begin
        regwrite = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        mem_we   = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        alu_op   = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                regdst = 1'b1;
                case (funct)
                    FN_ADD: begin regwrite = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin regwrite = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin regwrite = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin regwrite = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT: begin regwrite = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                memtoreg = 1'b1;
            end
            OP_SW: begin
                alusrc = 1'b1;
                mem_we = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file: $0 reads as zero and is never written
    assign rd1 = (rs == '0) ? '0 : rf[rs];
    assign rd2 = (rt == '0) ? '0 : rf[rt];
    assign wa  = regdst ? rd : rt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf <= '{default: '0};
        end else if (regwrite && (wa != '0)) begin
            rf[wa] <= result;
        end
    end

    // ALU
    assign srcb = alusrc ? imm_ext : rd2;

    always_comb begin
        aluresult = '0;
        case (alu_op)
            ALU_ADD: aluresult = rd1 + srcb;
            ALU_SUB: aluresult = rd1 - srcb;
            ALU_AND: aluresult = rd1 & srcb;
            ALU_OR:  aluresult = rd1 | srcb;
            ALU_SLT: aluresult = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(srcb))};
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

    // Data RAM keeps its contents across reset; word 0 of the ROM is never a store
    assign dmem_idx = DA_W'(aluresult[31:2] % 30'(DMEM_WORDS));
    assign readdata = dmem[dmem_idx];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[dmem_idx] <= rd2;
        end
    end

    assign result = memtoreg ? readdata : aluresult;

    // Next PC
    assign pc_plus4  = pc + 32'd4;
    assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign pc_jump   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = pc_jump;
        end else if (branch && zero) begin
            pc_next = pc_branch;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    assign writedata = rd2;
    assign dataadr   = aluresult;
    assign memwrite  = mem_we;

endmodule

// File: tb/tb_top.sv
// Bench for top: instruction-level reference model predicts stores into a scoreboard,
// a negedge monitor compares the exported store traffic; random run lengths and async resets.
module tb_top;

    logic        clk;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    top dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int n_seen = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } store_t;

    store_t sbq[$];

    // Reference machine state
    logic [31:0] prog [18] = '{
        32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824, 32'h00a42820,
        32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
        32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011, 32'h20020001, 32'hac020054
    };
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_dmem [int];

    logic        p_rw;
    logic [4:0]  p_rd;
    logic [31:0] p_val;
    logic        p_sw;
    logic [31:0] p_adr;
    logic [31:0] p_dat;
    logic [31:0] p_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_at(input int unsigned i);
        return (i < 18) ? prog[i] : 32'h0;
    endfunction

    task automatic iss_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // Work out what the instruction at m_pc does; state changes wait for iss_commit
    task automatic iss_exec();
        logic [31:0] w, a, b, simm, p4;
        int          idx;
        store_t      e;
        w    = rom_at((m_pc >> 2) % 64);
        a    = m_regs[w[25:21]];
        b    = m_regs[w[20:16]];
        simm = {{16{w[15]}}, w[15:0]};
        p4   = m_pc + 32'd4;
        p_rw = 1'b0; p_rd = 5'd0; p_val = 32'h0;
        p_sw = 1'b0; p_adr = 32'h0; p_dat = 32'h0;
        p_pc = p4;
        case (w[31:26])
            6'h00: begin
                p_rd = w[15:11];
                p_rw = 1'b1;
                case (w[5:0])
                    6'h20:   p_val = a + b;
                    6'h22:   p_val = a - b;
                    6'h24:   p_val = a & b;
                    6'h25:   p_val = a | b;
                    6'h2a:   p_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: p_rw = 1'b0;
                endcase
            end
            6'h23: begin
                idx   = int'(((a + simm) >> 2) % 64);
                p_rw  = 1'b1;
                p_rd  = w[20:16];
                p_val = m_dmem.exists(idx) ? m_dmem[idx] : 32'h0;
            end
            6'h2b: begin
                p_sw  = 1'b1;
                p_adr = a + simm;
                p_dat = b;
            end
            6'h04: if (a == b) p_pc = p4 + (simm << 2);
            6'h08: begin
                p_rw  = 1'b1;
                p_rd  = w[20:16];
                p_val = a + simm;
            end
            6'h02: p_pc = {p4[31:28], w[25:0], 2'b00};
            default: ;
        endcase
        if (p_sw) begin
            e.adr = p_adr;
            e.dat = p_dat;
            sbq.push_back(e);
        end
    endtask

    task automatic iss_commit();
        if (p_rw && p_rd != 5'd0) m_regs[p_rd] = p_val;
        if (p_sw) m_dmem[int'((p_adr >> 2) % 64)] = p_dat;
        m_pc = p_pc;
    endtask

    task automatic reset_checks();
        check("pc held in reset", dut.pc, 32'h0);
        check("memwrite in reset", 32'(memwrite), 32'h0);
        check("dataadr in reset", dataadr, 32'd5);
        check("writedata in reset", writedata, 32'h0);
        if (m_dmem.exists(20)) check("dmem word 20 retained", dut.dmem[20], m_dmem[20]);
    endtask

    // Release at posedge+1, run ncyc instructions, then assert reset between edges
    task automatic run(input int ncyc);
        int exp_st;
        int seen0;
        exp_st = 0;
        seen0  = n_seen;
        iss_reset();
        reset = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            check($sformatf("pc cycle %0d", c), dut.pc, m_pc);
            iss_exec();
            if (p_sw) exp_st++;
            @(posedge clk);
            #1;
            iss_commit();
            if (c == 16) begin
                check("reg2 final", dut.rf[2], 32'd7);
                check("reg3", dut.rf[3], 32'd12);
                check("reg4 slt 3<5", dut.rf[4], 32'd1);
                check("reg5 final", dut.rf[5], 32'd11);
                check("reg7", dut.rf[7], 32'd7);
                for (int i = 0; i < 32; i++)
                    check($sformatf("reg%0d vs model", i), dut.rf[i], m_regs[i]);
            end
        end
        #1 reset = 1'b0;
        sbq.delete();
        #1;
        check("pc async clear", dut.pc, 32'h0);
        for (int i = 0; i < 32; i++)
            check($sformatf("reg%0d async clear", i), dut.rf[i], 32'h0);
        check("dataadr async reset", dataadr, 32'd5);
        check("store count", 32'(n_seen - seen0), 32'(exp_st));
        iss_reset();
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            reset_checks();
        end
    endtask

    // Scoreboard monitor: one comparison slot per instruction cycle
    always @(negedge clk) begin
        store_t e;
        logic   want;
        if (!reset) begin
            check("memwrite during reset", 32'(memwrite), 32'h0);
        end else begin
            want = (sbq.size() > 0);
            check("memwrite", 32'(memwrite), 32'(want));
            if (memwrite === 1'b1) begin
                n_seen++;
                total++;
                if (dataadr != 32'd80 && dataadr != 32'd84) begin
                    bad++;
                    $display("FAIL store address: got %0d expected 80 or 84", dataadr);
                end
            end
            if (want) begin
                e = sbq.pop_front();
                if (memwrite === 1'b1) begin
                    check("store dataadr", dataadr, e.adr);
                    check("store writedata", writedata, e.dat);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        hold(2);
        // Long run: nops after word 17, then the ROM index wraps and the program re-executes
        run(130);
        hold(int'($urandom_range(1, 3)));
        for (int k = 0; k < 3; k++) begin
            run(int'($urandom_range(4, 12)));
            hold(int'($urandom_range(1, 3)));
        end
        run(20);
        hold(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
